// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants (reset PC, instruction width, PC step) and the fetch FSM state type
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction memory request/response bus
//   req/addr   : fetch -> memory request valid and address
//   ready      : memory accepts the request this cycle
//   valid/rdata: memory -> fetch response valid and instruction word
interface if_fetch_if;
  import cpu_pkg::*;
  logic req;
  logic [31:0] addr;
  logic ready;
  logic valid;
  logic [INSTR_W-1:0] rdata;
  modport master (output req, addr, input ready, valid, rdata);
  modport slave (input req, addr, output ready, valid, rdata);
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry instruction/PC output buffer
//   fill_i/consume_i/clear_i: load new entry / drain entry / discard entry (clear wins)
//   instr_i/pc_i            : entry contents written on fill
//   buf_valid_o             : buffer holds a live entry
//   instr_o/pc_o            : buffered entry; keep their last values when not valid
module fetch_buf
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               fill_i,
  input  logic               consume_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               buf_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o
);
  logic valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic load;
  assign load = fill_i && !clear_i;
  always_comb begin
    valid_d = clear_i ? 1'b0 : fill_i ? 1'b1 : consume_i ? 1'b0 : valid_q;
    instr_d = load ? instr_i : instr_q;
    pc_d = load ? pc_i : pc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
    end
  end
  assign buf_valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o = pc_q;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with one outstanding memory request and a one-entry output buffer
//   clk_i/rst_i            : clock, synchronous active-high reset
//   Stall_i                : downstream hold, buffer must not drain
//   Branch_i/BranchTarget_i: redirect request and target (low two bits ignored)
//   imem                   : instruction memory bus (master side)
//   Instruction_o/PC_o     : buffered instruction and its address
//   Valid_o                : buffer holds a live instruction
//   Flush_o                : flush to IF_ID, equal to Branch_i
//   FetchCnt_o/StallCnt_o  : consume and stall-cycle counters, present only with FETCH_PERF_CNT_EN
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               Stall_i,
  input  logic               Branch_i,
  input  logic [31:0]        BranchTarget_i,
  if_fetch_if.master         imem,
  output logic [INSTR_W-1:0] Instruction_o,
  output logic [31:0]        PC_o,
  output logic               Valid_o,
  output logic               Flush_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCnt_o,
  output logic [31:0]        StallCnt_o
`endif
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic buf_valid, consume, buf_free, fill;
  logic unused_tgt;
  assign unused_tgt = ^BranchTarget_i[1:0];
  assign consume = buf_valid && !Stall_i;
  assign buf_free = !buf_valid || consume;
  assign Flush_o = Branch_i;
  assign Valid_o = buf_valid;
  // Requests are only issued when the buffer will be free, so a response can always be stored.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fill = 1'b0;
    imem.req = 1'b0;
    imem.addr = pc_q;
    case (state_q)
      IDLE: begin
        imem.req = buf_free && !Branch_i && !rst_i;
        if (imem.req && imem.ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.valid) begin
          state_d = IDLE;
          fill = !Branch_i;
          pc_d = pc_q + PC_INC;
        end else if (Branch_i) begin
          state_d = DROP;
        end
      end
      default: if (imem.valid) state_d = IDLE;
    endcase
    if (Branch_i) pc_d = {BranchTarget_i[31:2], 2'b00};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  fetch_buf u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fill_i      (fill),
    .consume_i   (consume),
    .clear_i     (Branch_i),
    .instr_i     (imem.rdata),
    .pc_i        (pc_q),
    .buf_valid_o (buf_valid),
    .instr_o     (Instruction_o),
    .pc_o        (PC_o)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, consume};
    stall_cnt_d = stall_cnt_q + {31'd0, buf_valid && Stall_i};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign FetchCnt_o = fetch_cnt_q;
  assign StallCnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized check of if_fetch against a queue-based fetch model
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0;
  logic clk = 1'b0;
  logic rst_i, Stall_i, Branch_i;
  logic [31:0] BranchTarget_i;
  logic [31:0] Instruction_o, PC_o;
  logic Valid_o, Flush_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt_o, StallCnt_o;
`endif
  if_fetch_if imem ();
  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .Stall_i        (Stall_i),
    .Branch_i       (Branch_i),
    .BranchTarget_i (BranchTarget_i),
    .imem           (imem),
    .Instruction_o  (Instruction_o),
    .PC_o           (PC_o),
    .Valid_o        (Valid_o),
    .Flush_o        (Flush_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCnt_o     (FetchCnt_o),
    .StallCnt_o     (StallCnt_o)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
  endfunction

  // Reference model: outstanding request queue with a keep flag, one-slot buffer, next fetch address.
  typedef struct packed {logic [31:0] addr; bit keep;} req_t;
  req_t outq[$];
  bit en = 0;
  bit m_full;
  logic [31:0] m_pc, last_pc, last_instr, m_fetch, m_stall;
  task automatic model_reset();
    outq.delete();
    m_full = 0;
    m_pc = RST_PC;
    last_pc = 0;
    last_instr = 0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  always @(negedge clk) if (en) begin
    bit er;
    req_t r;
    er = !rst_i && outq.size() == 0 && (!m_full || !Stall_i) && !Branch_i;
    chk("req", {31'd0, imem.req}, {31'd0, er});
    if (er) chk("addr", imem.addr, m_pc);
    chk("flush", {31'd0, Flush_o}, {31'd0, Branch_i});
    chk("valid", {31'd0, Valid_o}, {31'd0, m_full});
    chk("pc_o", PC_o, last_pc);
    chk("instr", Instruction_o, last_instr);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", FetchCnt_o, m_fetch);
    chk("stall_cnt", StallCnt_o, m_stall);
`endif
    if (rst_i) model_reset();
    else begin
      if (m_full && Stall_i) m_stall++;
      if (m_full && !Stall_i) begin
        m_full = 0;
        m_fetch++;
      end
      if (imem.valid && outq.size() != 0) begin
        r = outq.pop_front();
        if (r.keep && !Branch_i) begin
          m_full = 1;
          last_pc = r.addr;
          last_instr = imem.rdata;
          m_pc = r.addr + 32'd4;
        end
      end
      if (er && imem.ready) outq.push_back('{addr: m_pc, keep: 1'b1});
      if (Branch_i) begin
        foreach (outq[i]) outq[i].keep = 0;
        m_full = 0;
        m_pc = {BranchTarget_i[31:2], 2'b00};
      end
    end
  end

  // Memory side: one pending request answered after dly extra cycles.
  bit pend = 0;
  int dly = 0;
  int lat_mode = 0;
  logic [31:0] paddr = 0;
  bit s_req, s_flush, acc, resp;
  logic [31:0] s_addr;
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit rdy);
    rst_i = r;
    Stall_i = s;
    Branch_i = b;
    BranchTarget_i = t;
    imem.ready = rdy;
    imem.valid = pend && dly == 0;
    imem.rdata = imem.valid ? mw(paddr) : $urandom;
    @(negedge clk);
    s_req = imem.req;
    s_addr = imem.addr;
    s_flush = Flush_o;
    acc = imem.req && rdy;
    resp = imem.valid;
    @(posedge clk);
    #1;
    if (r || resp) pend = 0;
    else if (pend) dly--;
    if (!r && acc) begin
      pend = 1;
      paddr = s_addr;
      dly = lat_mode < 0 ? int'($urandom_range(0, 3)) : lat_mode;
    end
  endtask

  initial begin
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] sc0;
`endif
    rst_i = 1;
    Stall_i = 0;
    Branch_i = 0;
    BranchTarget_i = 0;
    imem.ready = 0;
    imem.valid = 0;
    imem.rdata = 0;
    model_reset();
    @(posedge clk);
    #1;
    en = 1;
    lat_mode = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      chk("seq_req", {31'd0, s_req}, 32'd1);
      chk("seq_addr", s_addr, 32'(4 * k));
      step(0, 0, 0, 0, 1);
      chk("seq_valid", {31'd0, Valid_o}, 32'd1);
      chk("seq_pc", PC_o, 32'(4 * k));
      chk("seq_instr", Instruction_o, mw(32'(4 * k)));
    end
`ifdef FETCH_PERF_CNT_EN
    sc0 = StallCnt_o;
`endif
    repeat (3) begin
      step(0, 1, 0, 0, 1);
      chk("stall_req", {31'd0, s_req}, 32'd0);
      chk("stall_pc", PC_o, 32'h8);
      chk("stall_valid", {31'd0, Valid_o}, 32'd1);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt_delta", StallCnt_o - sc0, 32'd3);
`endif
    lat_mode = 1;
    step(0, 0, 0, 0, 1);
    chk("resume_addr", s_addr, 32'hC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("fill_pc", PC_o, 32'hC);
    step(0, 0, 0, 0, 1);
    chk("req_10", s_addr, 32'h10);
    step(0, 0, 1, 32'h40, 1);
    chk("drop_flush", {31'd0, s_flush}, 32'd1);
    chk("drop_noreq", {31'd0, s_req}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("drop_valid", {31'd0, Valid_o}, 32'd0);
    chk("drop_flush_off", {31'd0, s_flush}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("redir_req", {31'd0, s_req}, 32'd1);
    chk("redir_addr", s_addr, 32'h40);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h103, 1);
    chk("same_cycle_valid", {31'd0, Valid_o}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("align_addr", s_addr, 32'h100);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("br_idle_noreq", {31'd0, s_req}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("top_addr", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("top_pc", PC_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("wrap_addr", s_addr, 32'h0);
    step(1, 0, 0, 0, 1);
    chk("rst_noreq", {31'd0, s_req}, 32'd0);
    chk("rst_valid", {31'd0, Valid_o}, 32'd0);
    chk("rst_pc_o", PC_o, 32'h0);
    chk("rst_instr", Instruction_o, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("post_rst_req", {31'd0, s_req}, 32'd1);
    chk("post_rst_addr", s_addr, RST_PC);
    lat_mode = -1;
    repeat (4000)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
           $urandom, $urandom_range(0, 99) < 70);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
